scan_select_gen: RTL and testbench

//  Upstream driver for the 2-to-4 line decoder stage. Steps a 2-bit select code
//  00->01->10->11->00 at a programmable rate. sel_i1/sel_i0 wire directly to the

---
 rtl/scan_select_gen.sv | 110 +++++++++++
 tb/tb_scan_select_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/scan_select_gen.sv
// scan_select_gen
//   Drives the 2-bit select code of a 2-to-4 line decoder, stepping
//   00 -> 01 -> 10 -> 11 -> 00 with every slot lasting PRESCALE cycles.
//   scan_valid gates the decoded one-hot lines downstream.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   en          in   scan enable; 0 stops and returns to slot 00
//   hold        in   freeze prescaler and slot; outputs keep their values
//   sel_i1      out  select MSB (decoder i1)
//   sel_i0      out  select LSB (decoder i0)
//   scan_valid  out  decoded output is valid
//   slot_tick   out  1-cycle pulse in the first cycle of each new slot
//   frame_done  out  1-cycle pulse on the 11 -> 00 wrap
//
// Configuration macro
//   SCAN_BLANK_EN : blank scan_valid during the first cycle of every slot
//                   (requires PRESCALE >= 2).

module scan_select_gen #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hold,
    output logic sel_i1,
    output logic sel_i0,
    output logic scan_valid,
    output logic slot_tick,
    output logic frame_done
);

    // Elaboration-time parameter checks
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("scan_select_gen: PRESCALE out of range 1..65535");
    end
    if (((PRESCALE - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("scan_select_gen: CNT_W too narrow for PRESCALE");
    end
`ifdef SCAN_BLANK_EN
    if (PRESCALE < 2) begin : g_bad_blank
        $error("scan_select_gen: SCAN_BLANK_EN needs PRESCALE >= 2");
    end
`endif

    localparam logic [CNT_W-1:0] TC = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic             valid_q, valid_d;
    logic             tick_q, tick_d;
    logic             frame_q, frame_d;
    logic             term;

    assign term = (cnt_q == TC);

    always_comb begin
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        if (!en) begin
            cnt_d   = '0;
            slot_d  = 2'b00;
            valid_d = 1'b0;
        end else if (!hold) begin
            if (term) begin
                cnt_d   = '0;
                slot_d  = slot_q + 2'd1;
                tick_d  = 1'b1;
                frame_d = (slot_q == 2'b11);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef SCAN_BLANK_EN
            // Blank the cycle in which the decoder output switches.
            valid_d = !term;
`else
            valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            slot_q  <= 2'b00;
            valid_q <= 1'b0;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign sel_i1     = slot_q[1];
    assign sel_i0     = slot_q[0];
    assign scan_valid = valid_q;
    assign slot_tick  = tick_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_scan_select_gen.sv
module tb_scan_select_gen;

    typedef struct packed {
        logic [1:0] sel;
        logic       v;
        logic       t;
        logic       f;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0, en = 1'b0, hold = 1'b0;
    logic s1_a, s0_a, v_a, t_a, f_a;
    logic s1_b, s0_b, v_b, t_b, f_b;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference state: n = advancing cycles since the last reset/disable.
    int n_a = 0, n_b = 0;
    bit v_ma = 0, v_mb = 0;

    always #5 clk = ~clk;

    scan_select_gen #(.PRESCALE(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hold(hold),
        .sel_i1(s1_a), .sel_i0(s0_a), .scan_valid(v_a),
        .slot_tick(t_a), .frame_done(f_a)
    );

`ifndef SCAN_BLANK_EN
    scan_select_gen #(.PRESCALE(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .hold(hold),
        .sel_i1(s1_b), .sel_i0(s0_b), .scan_valid(v_b),
        .slot_tick(t_b), .frame_done(f_b)
    );
`else
    assign {s1_b, s0_b, v_b, t_b, f_b} = '0;
`endif

    // Slot index = floor(n / P) mod 4; a tick occurs when an advancing
    // cycle makes n a multiple of P.
    task automatic model(input int p, inout int n, inout bit v,
                         input bit r, input bit e, input bit h,
                         output exp_t x);
        bit t = 0, f = 0;
        if (!r || !e) begin
            n = 0;
            v = 0;
        end else if (!h) begin
            n = n + 1;
            t = (n % p) == 0;
            f = t && ((n / p) % 4) == 0;
`ifdef SCAN_BLANK_EN
            v = !t;
`else
            v = 1;
`endif
        end
        x.sel = 2'((n / p) % 4);
        x.v   = v;
        x.t   = t;
        x.f   = f;
    endtask

    task automatic cyc(input bit r, input bit e, input bit h);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        en    = e;
        hold  = h;
        model(4, n_a, v_ma, r, e, h, x);
        q_a.push_back(x);
`ifndef SCAN_BLANK_EN
        model(1, n_b, v_mb, r, e, h, x);
        q_b.push_back(x);
`endif
    endtask

    task automatic check_one(input string nm, input exp_t x,
                             input logic s1, input logic s0, input logic v,
                             input logic t, input logic f);
        logic [3:0] dec, dec_exp;
        checks++;
        if ({s1, s0, v, t, f} !== x) begin
            errors++;
            $display("FAIL %s cyc %0d: got sel=%b%b valid=%b tick=%b frame=%b, want sel=%b valid=%b tick=%b frame=%b",
                     nm, cycle, s1, s0, v, t, f, x.sel, x.v, x.t, x.f);
        end
        dec     = v ? (4'b0001 << {s1, s0}) : 4'b0000;
        dec_exp = x.v ? (4'b0001 << x.sel) : 4'b0000;
        checks++;
        if (dec !== dec_exp) begin
            errors++;
            $display("FAIL %s onehot cyc %0d: got %b want %b", nm, cycle, dec, dec_exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q_a.size() > 0) begin
                x = q_a.pop_front();
                check_one("p4", x, s1_a, s0_a, v_a, t_a, f_a);
            end
            if (q_b.size() > 0) begin
                x = q_b.pop_front();
                check_one("p1", x, s1_b, s0_b, v_b, t_b, f_b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // T1: reset held with en=1
        repeat (3) cyc(0, 1, 0);
        // T2: free-running scan
        repeat (20) cyc(1, 1, 0);
        // T3: hold in mid slot 01
        repeat (2) cyc(1, 1, 0);
        repeat (3) cyc(1, 1, 1);
        repeat (6) cyc(1, 1, 0);
        // T4: drop en exactly at terminal count of slot 10
        guard = 0;
        while (!((n_a % 4) == 3 && ((n_a / 4) % 4) == 2) && guard < 32) begin
            cyc(1, 1, 0);
            guard++;
        end
        checks++;
        if (guard >= 32) begin
            errors++;
            $display("FAIL t4_reach: got guard=%0d want <32", guard);
        end
        cyc(1, 0, 0);
        repeat (10) cyc(1, 1, 0);
        // Hold coinciding with terminal count
        while ((n_a % 4) != 3) cyc(1, 1, 0);
        repeat (2) cyc(1, 1, 1);
        repeat (3) cyc(1, 1, 0);
        // Randomized traffic
        repeat (600) begin
            cyc(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) >= 8),
                ($urandom_range(0, 99) < 20));
        end
        repeat (12) cyc(1, 1, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
